// File: rtl/alu_design.sv
// rtl/alu_design.sv - pipelined arithmetic/logic unit with registered 2W-bit result and flags
module alu_design #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ce,
    input  logic           mode,
    input  logic           cin,
    input  logic [1:0]     inp_valid,
    input  logic [3:0]     cmd,
    input  logic [W-1:0]   opa,
    input  logic [W-1:0]   opb,
    output logic [2*W-1:0] res,
    output logic           cout,
    output logic           ov,
    output logic           g,
    output logic           l,
    output logic           e,
    output logic           err
);
    localparam int LW = $clog2(W);
    localparam logic [2*W-1:0] ONE2 = {{(2*W-1){1'b0}}, 1'b1};
    localparam logic [W:0]     ONE1 = {{W{1'b0}}, 1'b1};

    logic [W-1:0]   a_q, b_q;
    logic [3:0]     cmd_q;
    logic           mode_q, cin_q;
    logic [1:0]     vld_q;
    logic [2*W-1:0] mul_q;
    logic           mul_pend;

    logic [W:0]     ax, bx, cx, sa, sb;
    logic [W:0]     add_r, addc_r, sub_r, subc_r, sadd_r, ssub_r;
    logic [2*W-1:0] rol_t, ror_t, ea, eb, mul_inc, mul_shl, mul_n;
    logic [W-1:0]   shl_a, rol_r, ror_r;
    logic           rot_err, a_only, b_only, undef, ops_ok, mul_go;

    logic [2*W-1:0] res_n;
    logic           cout_n, ov_n, g_n, l_n, e_n, err_n;

    assign ax     = {1'b0, a_q};
    assign bx     = {1'b0, b_q};
    assign cx     = {{W{1'b0}}, cin_q};
    assign sa     = {a_q[W-1], a_q};
    assign sb     = {b_q[W-1], b_q};
    assign add_r  = ax + bx;
    assign addc_r = ax + bx + cx;
    assign sub_r  = ax - bx;
    assign subc_r = ax - bx - cx;
    assign sadd_r = sa + sb;
    assign ssub_r = sa - sb;

    // Rotates use a doubled operand so the wrapped bits fall into the kept half.
    assign rol_t   = {a_q, a_q} << b_q[LW-1:0];
    assign ror_t   = {a_q, a_q} >> b_q[LW-1:0];
    assign rol_r   = rol_t[2*W-1:W];
    assign ror_r   = ror_t[W-1:0];
    assign rot_err = |b_q[W-1:LW];

    assign ea      = {{W{1'b0}}, a_q} + ONE2;
    assign eb      = {{W{1'b0}}, b_q} + ONE2;
    assign shl_a   = {a_q[W-2:0], 1'b0};
    assign mul_inc = ea * eb;
    assign mul_shl = {{W{1'b0}}, shl_a} * {{W{1'b0}}, b_q};
    assign mul_n   = cmd_q[0] ? mul_inc : mul_shl;

    assign a_only = mode_q ? (cmd_q == 4'd4 || cmd_q == 4'd5)
                           : (cmd_q == 4'd6 || cmd_q == 4'd8 || cmd_q == 4'd9);
    assign b_only = mode_q ? (cmd_q == 4'd6 || cmd_q == 4'd7)
                           : (cmd_q == 4'd7 || cmd_q == 4'd10 || cmd_q == 4'd11);
    assign undef  = mode_q ? (cmd_q > 4'd12) : (cmd_q > 4'd13);
    assign ops_ok = a_only ? vld_q[0] : (b_only ? vld_q[1] : (vld_q == 2'b11));
    assign mul_go = mode_q && (cmd_q == 4'd9 || cmd_q == 4'd10) && (vld_q == 2'b11);

    always_comb begin
        res_n  = '0;
        cout_n = 1'b0;
        ov_n   = 1'b0;
        g_n    = 1'b0;
        l_n    = 1'b0;
        e_n    = 1'b0;
        err_n  = 1'b0;
        if (undef || !ops_ok) begin
            err_n = 1'b1;
        end else if (mode_q) begin
            case (cmd_q)
                4'd0:  begin res_n = {{(W-1){1'b0}}, add_r};  cout_n = add_r[W];  end
                4'd1:  begin res_n = {{(W-1){1'b0}}, sub_r};  ov_n = ax < bx;      end
                4'd2:  begin res_n = {{(W-1){1'b0}}, addc_r}; cout_n = addc_r[W]; end
                4'd3:  begin res_n = {{(W-1){1'b0}}, subc_r}; ov_n = ax < (bx + cx); end
                4'd4:  res_n = {{(W-1){1'b0}}, ax + ONE1};
                4'd5:  res_n = {{(W-1){1'b0}}, ax - ONE1};
                4'd6:  res_n = {{(W-1){1'b0}}, bx + ONE1};
                4'd7:  res_n = {{(W-1){1'b0}}, bx - ONE1};
                4'd8:  begin g_n = a_q > b_q; l_n = a_q < b_q; e_n = a_q == b_q; end
                4'd11: begin
                    res_n = {{(W-1){sadd_r[W]}}, sadd_r};
                    ov_n  = sadd_r[W] ^ sadd_r[W-1];
                    g_n   = $signed(a_q) > $signed(b_q);
                    l_n   = $signed(a_q) < $signed(b_q);
                    e_n   = a_q == b_q;
                end
                4'd12: begin
                    res_n = {{(W-1){ssub_r[W]}}, ssub_r};
                    ov_n  = ssub_r[W] ^ ssub_r[W-1];
                    g_n   = $signed(a_q) > $signed(b_q);
                    l_n   = $signed(a_q) < $signed(b_q);
                    e_n   = a_q == b_q;
                end
                default: res_n = '0;
            endcase
        end else begin
            case (cmd_q)
                4'd0:  res_n = {{W{1'b0}}, a_q & b_q};
                4'd1:  res_n = {{W{1'b0}}, ~(a_q & b_q)};
                4'd2:  res_n = {{W{1'b0}}, a_q | b_q};
                4'd3:  res_n = {{W{1'b0}}, ~(a_q | b_q)};
                4'd4:  res_n = {{W{1'b0}}, a_q ^ b_q};
                4'd5:  res_n = {{W{1'b0}}, ~(a_q ^ b_q)};
                4'd6:  res_n = {{W{1'b0}}, ~a_q};
                4'd7:  res_n = {{W{1'b0}}, ~b_q};
                4'd8:  res_n = {{W{1'b0}}, 1'b0, a_q[W-1:1]};
                4'd9:  res_n = {{W{1'b0}}, a_q[W-2:0], 1'b0};
                4'd10: res_n = {{W{1'b0}}, 1'b0, b_q[W-1:1]};
                4'd11: res_n = {{W{1'b0}}, b_q[W-2:0], 1'b0};
                4'd12: begin res_n = {{W{1'b0}}, rol_r}; err_n = rot_err; end
                4'd13: begin res_n = {{W{1'b0}}, ror_r}; err_n = rot_err; end
                default: err_n = 1'b1;
            endcase
        end
    end

    // Multiplies park in mul_q for one edge; outputs hold meanwhile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            cmd_q    <= '0;
            mode_q   <= 1'b0;
            cin_q    <= 1'b0;
            vld_q    <= '0;
            mul_q    <= '0;
            mul_pend <= 1'b0;
            res      <= '0;
            cout     <= 1'b0;
            ov       <= 1'b0;
            g        <= 1'b0;
            l        <= 1'b0;
            e        <= 1'b0;
            err      <= 1'b0;
        end else if (ce) begin
            a_q      <= opa;
            b_q      <= opb;
            cmd_q    <= cmd;
            mode_q   <= mode;
            cin_q    <= cin;
            vld_q    <= inp_valid;
            mul_pend <= mul_go;
            if (mul_go) begin
                mul_q <= mul_n;
            end
            if (!mul_go) begin
                res  <= res_n;
                cout <= cout_n;
                ov   <= ov_n;
                g    <= g_n;
                l    <= l_n;
                e    <= e_n;
                err  <= err_n;
            end else if (mul_pend) begin
                res  <= mul_q;
                cout <= 1'b0;
                ov   <= 1'b0;
                g    <= 1'b0;
                l    <= 1'b0;
                e    <= 1'b0;
                err  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_design.sv
// tb/tb_alu_design.sv - scoreboard bench for alu_design (W=8)
module tb_alu_design;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst, ce, mode, cin;
    logic [1:0]     inp_valid;
    logic [3:0]     cmd;
    logic [W-1:0]   opa, opb;
    logic [2*W-1:0] res;
    logic           cout, ov, g, l, e, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] res;
        logic        cout, ov, g, l, e, err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    alu_design #(.W(W)) dut (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .cin(cin),
        .inp_valid(inp_valid), .cmd(cmd), .opa(opa), .opb(opb),
        .res(res), .cout(cout), .ov(ov), .g(g), .l(l), .e(e), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic co, input logic o,
                                input logic gg, input logic ll, input logic ee,
                                input logic er, input int lat);
        exp_t x;
        x.res = r; x.cout = co; x.ov = o; x.g = gg; x.l = ll; x.e = ee; x.err = er; x.lat = lat;
        return x;
    endfunction

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input logic m, input logic [3:0] c, input logic [7:0] a,
                                   input logic [7:0] b, input logic [1:0] v, input logic ci);
        exp_t x;
        int ia, ib, sa, sb, r, amt;
        bit aonly, bonly, undef, ok;
        x = mk(16'h0, 0, 0, 0, 0, 0, 0, 2);
        ia = int'(a); ib = int'(b); ci_blk: begin end
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        r = 0;
        aonly = m ? (c == 4 || c == 5) : (c == 6 || c == 8 || c == 9);
        bonly = m ? (c == 6 || c == 7) : (c == 7 || c == 10 || c == 11);
        undef = m ? (c > 12) : (c > 13);
        ok = aonly ? v[0] : (bonly ? v[1] : (v == 2'b11));
        if (undef || !ok) begin
            x.err = 1'b1;
            return x;
        end
        if (m) begin
            case (c)
                0: begin r = ia + ib; x.cout = (r > 255); end
                1: begin r = (ia - ib) & 'h1FF; x.ov = (ia < ib); end
                2: begin r = ia + ib + int'(ci); x.cout = (r > 255); end
                3: begin r = (ia - ib - int'(ci)) & 'h1FF; x.ov = (ia < ib + int'(ci)); end
                4: r = ia + 1;
                5: r = (ia - 1) & 'h1FF;
                6: r = ib + 1;
                7: r = (ib - 1) & 'h1FF;
                8: begin x.g = ia > ib; x.l = ia < ib; x.e = ia == ib; end
                9: begin r = ((ia + 1) * (ib + 1)) & 'hFFFF; x.lat = 3; end
                10: begin r = (((ia * 2) & 'hFF) * ib) & 'hFFFF; x.lat = 3; end
                11, 12: begin
                    r = (c == 11) ? sa + sb : sa - sb;
                    x.ov = (r > 127) || (r < -128);
                    r = r & 'hFFFF;
                    x.g = sa > sb; x.l = sa < sb; x.e = sa == sb;
                end
                default: r = 0;
            endcase
        end else begin
            amt = ib % 8;
            case (c)
                0: r = ia & ib;
                1: r = ~(ia & ib);
                2: r = ia | ib;
                3: r = ~(ia | ib);
                4: r = ia ^ ib;
                5: r = ~(ia ^ ib);
                6: r = ~ia;
                7: r = ~ib;
                8: r = ia / 2;
                9: r = ia * 2;
                10: r = ib / 2;
                11: r = ib * 2;
                12: begin r = (ia << amt) | (ia >> (8 - amt)); x.err = (ib > 7); end
                default: begin r = (ia >> amt) | (ia << (8 - amt)); x.err = (ib > 7); end
            endcase
            r = r & 'hFF;
        end
        x.res = 16'(r);
        return x;
    endfunction

    task automatic compare_out(input string tag, input exp_t x);
        check({tag, ".res"},  32'(res),  32'(x.res));
        check({tag, ".cout"}, 32'(cout), 32'(x.cout));
        check({tag, ".ov"},   32'(ov),   32'(x.ov));
        check({tag, ".g"},    32'(g),    32'(x.g));
        check({tag, ".l"},    32'(l),    32'(x.l));
        check({tag, ".e"},    32'(e),    32'(x.e));
        check({tag, ".err"},  32'(err),  32'(x.err));
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic [1:0] v, input logic ci);
        mode = m; cmd = c; opa = a; opb = b; inp_valid = v; cin = ci;
    endtask

    task automatic run_op(input string tag, input logic m, input logic [3:0] c,
                          input logic [7:0] a, input logic [7:0] b, input logic [1:0] v,
                          input logic ci, input exp_t x);
        exp_t got_x;
        @(negedge clk);
        drive(m, c, a, b, v, ci);
        sb_q.push_back(x);
        repeat (x.lat) @(negedge clk);
        got_x = sb_q.pop_front();
        compare_out(tag, got_x);
    endtask

    exp_t zero_x, last_x, rx;
    logic        rm, rci;
    logic [3:0]  rc;
    logic [7:0]  ra, rb;
    logic [1:0]  rv;

    initial begin
        zero_x = mk(16'h0, 0, 0, 0, 0, 0, 0, 2);
        rst = 1'b0; ce = 1'b1;
        drive(1'b1, 4'd0, 8'hFF, 8'h01, 2'b11, 1'b0);
        repeat (2) @(negedge clk);
        compare_out("reset_state", zero_x);
        rst = 1'b1;

        run_op("sub_borrow", 1, 4'd1, 8'h05, 8'h0A, 2'b11, 0, mk(16'h01FB, 0, 1, 0, 0, 0, 0, 2));

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        drive(1'b1, 4'd2, 8'h80, 8'h80, 2'b11, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 compare_out("reset_async", zero_x);
        @(negedge clk);
        compare_out("reset_hold", zero_x);
        rst = 1'b1;
        run_op("add_after_rst", 1, 4'd0, 8'hFF, 8'h01, 2'b11, 0, mk(16'h0100, 1, 0, 0, 0, 0, 0, 2));

        run_op("cmp_eq",     1, 4'd8,  8'h3C, 8'h3C, 2'b11, 0, mk(16'h0000, 0, 0, 0, 0, 1, 0, 2));
        run_op("mul_inc",    1, 4'd9,  8'h02, 8'h03, 2'b11, 0, mk(16'h000C, 0, 0, 0, 0, 0, 0, 3));
        run_op("inc_a_bad",  1, 4'd4,  8'h10, 8'h20, 2'b10, 0, mk(16'h0000, 0, 0, 0, 0, 0, 1, 2));
        run_op("log_undef",  0, 4'd15, 8'h10, 8'h20, 2'b11, 0, mk(16'h0000, 0, 0, 0, 0, 0, 1, 2));
        run_op("nand",       0, 4'd1,  8'hF0, 8'hCC, 2'b11, 0, mk(16'h003F, 0, 0, 0, 0, 0, 0, 2));
        run_op("rol",        0, 4'd12, 8'h81, 8'h01, 2'b11, 0, mk(16'h0003, 0, 0, 0, 0, 0, 0, 2));
        last_x = mk(16'h0003, 0, 0, 0, 0, 0, 1, 2);
        run_op("rol_err",    0, 4'd12, 8'h81, 8'h11, 2'b11, 0, last_x);

        // Clock enable low: inputs change, outputs stay put.
        @(negedge clk);
        ce = 1'b0;
        drive(1'b1, 4'd0, 8'h55, 8'h66, 2'b11, 1'b0);
        repeat (3) @(negedge clk);
        compare_out("ce_freeze", last_x);
        ce = 1'b1;
        run_op("sadd_ovf",   1, 4'd11, 8'h7F, 8'h01, 2'b11, 0, mk(16'h0080, 0, 1, 1, 0, 0, 0, 2));

        // Operation in flight pauses under ce=0 and completes afterwards.
        @(negedge clk);
        drive(1'b1, 4'd3, 8'h10, 8'h10, 2'b11, 1'b1);
        @(negedge clk);
        ce = 1'b0;
        repeat (3) @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        compare_out("ce_resume", mk(16'h01FF, 0, 1, 0, 0, 0, 0, 2));

        run_op("ssub_neg",   1, 4'd12, 8'h80, 8'h01, 2'b11, 0, mk(16'h FF7F, 0, 1, 0, 1, 0, 0, 2));

        for (int i = 0; i < 60; i++) begin
            rm  = 1'($urandom_range(0, 1));
            rc  = 4'($urandom_range(0, 15));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rv  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            rci = 1'($urandom_range(0, 1));
            rx  = model(rm, rc, ra, rb, rv, rci);
            run_op($sformatf("rand%0d_m%0d_c%0d", i, rm, rc), rm, rc, ra, rb, rv, rci, rx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
